// File: rtl/fifo_pkg.sv
// Shared encodings for the 8-entry FIFO and the scheduler in front of it.
package fifo_pkg;

    localparam int DEPTH = 8;

    // FIFO controller states, as seen on the FIFO side.
    typedef enum logic [2:0] {
        FIFO_INIT     = 3'd0,
        FIFO_WRITE    = 3'd1,
        FIFO_READ     = 3'd2,
        FIFO_WR_ERROR = 3'd3,
        FIFO_RD_ERROR = 3'd4,
        FIFO_NO_OP    = 3'd5
    } fifo_state_e;

    // Scheduler state, exported on the state port.
    typedef enum logic [1:0] {
        ARB_IDLE  = 2'b00,
        ARB_WRITE = 2'b01,
        ARB_READ  = 2'b10,
        ARB_STALL = 2'b11
    } arb_state_e;

    // Positions on the round-robin ring W0 -> W1 -> RD -> W0.
    localparam logic [1:0] REQ_W0 = 2'd0;
    localparam logic [1:0] REQ_W1 = 2'd1;
    localparam logic [1:0] REQ_RD = 2'd2;

endpackage

// File: rtl/fifo_arbiter_if.sv
// Producer/consumer request side and FIFO strobe side of the scheduler.
interface fifo_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_W      = 4
);
    logic                  req0;
    logic                  req1;
    logic [DATA_WIDTH-1:0] din0;
    logic [DATA_WIDTH-1:0] din1;
    logic                  rd_req;
    logic                  wr_en;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  gnt0;
    logic                  gnt1;
    logic                  rd_gnt;
    logic [CNT_W-1:0]      occ;
    logic                  full;
    logic                  empty;
    logic [1:0]            state;

    // Requesters drive the requests and observe grants/strobes.
    modport master (
        output req0, req1, din0, din1, rd_req,
        input  wr_en, rd_en, wr_data, gnt0, gnt1, rd_gnt, occ, full, empty, state
    );

    // The scheduler consumes requests and drives everything else.
    modport slave (
        input  req0, req1, din0, din1, rd_req,
        output wr_en, rd_en, wr_data, gnt0, gnt1, rd_gnt, occ, full, empty, state
    );
endinterface

// File: rtl/fifo_arbiter_rr_pick3.sv
// Three-way round-robin picker: search starts one past the last winner.
module rr_pick3 (
    input  logic [2:0] elig_i,
    input  logic [1:0] last_i,
    output logic [2:0] pick_o,
    output logic       valid_o
);
    import fifo_pkg::*;

    // Walk the ring in order starting after last_i; first eligible wins.
    always_comb begin
        pick_o = 3'b000;
        case (last_i)
            REQ_W0: begin
                if      (elig_i[1]) pick_o = 3'b010;
                else if (elig_i[2]) pick_o = 3'b100;
                else if (elig_i[0]) pick_o = 3'b001;
            end
            REQ_W1: begin
                if      (elig_i[2]) pick_o = 3'b100;
                else if (elig_i[0]) pick_o = 3'b001;
                else if (elig_i[1]) pick_o = 3'b010;
            end
            default: begin
                if      (elig_i[0]) pick_o = 3'b001;
                else if (elig_i[1]) pick_o = 3'b010;
                else if (elig_i[2]) pick_o = 3'b100;
            end
        endcase
    end

    assign valid_o = |elig_i;

endmodule

// File: rtl/fifo_arbiter.sv
// Scheduler sharing one FIFO between two producers and one consumer.
// Keeps a shadow occupancy so the FIFO never sees an illegal operation.
module fifo_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = fifo_pkg::DEPTH,
    parameter int CNT_W      = 4
) (
    input logic           clk,
    input logic           reset_n,
    fifo_arbiter_if.slave bus
);
    import fifo_pkg::*;

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    logic                  wr_en_q,   wr_en_d;
    logic                  rd_en_q,   rd_en_d;
    logic                  gnt0_q,    gnt0_d;
    logic                  gnt1_q,    gnt1_d;
    logic                  rd_gnt_q,  rd_gnt_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [CNT_W-1:0]      occ_q,     occ_d;
    logic [1:0]            last_q,    last_d;
    arb_state_e            state_q,   state_d;

    logic       full_w;
    logic       empty_w;
    logic [2:0] elig;
    logic [2:0] pick;
    logic       pick_vld;

    assign full_w  = (occ_q == DEPTH_C);
    assign empty_w = (occ_q == '0);

    // A requester granted in this cycle sits out the next edge.
    assign elig[0] = bus.req0   && !full_w  && !gnt0_q;
    assign elig[1] = bus.req1   && !full_w  && !gnt1_q;
    assign elig[2] = bus.rd_req && !empty_w && !rd_gnt_q;

    rr_pick3 u_pick (
        .elig_i  (elig),
        .last_i  (last_q),
        .pick_o  (pick),
        .valid_o (pick_vld)
    );

    // Next-state: load strobes/grants for the winner, or idle/stall.
    always_comb begin
        wr_en_d   = 1'b0;
        rd_en_d   = 1'b0;
        gnt0_d    = 1'b0;
        gnt1_d    = 1'b0;
        rd_gnt_d  = 1'b0;
        wr_data_d = wr_data_q;
        occ_d     = occ_q;
        last_d    = last_q;
        state_d   = ARB_IDLE;
        if (pick_vld && pick[0]) begin
            wr_en_d   = 1'b1;
            gnt0_d    = 1'b1;
            wr_data_d = bus.din0;
            occ_d     = occ_q + ONE_C;
            last_d    = REQ_W0;
            state_d   = ARB_WRITE;
        end else if (pick_vld && pick[1]) begin
            wr_en_d   = 1'b1;
            gnt1_d    = 1'b1;
            wr_data_d = bus.din1;
            occ_d     = occ_q + ONE_C;
            last_d    = REQ_W1;
            state_d   = ARB_WRITE;
        end else if (pick_vld && pick[2]) begin
            rd_en_d   = 1'b1;
            rd_gnt_d  = 1'b1;
            occ_d     = occ_q - ONE_C;
            last_d    = REQ_RD;
            state_d   = ARB_READ;
        end else if (((bus.req0 || bus.req1) && full_w) || (bus.rd_req && empty_w)) begin
            // Someone is waiting only because of the occupancy limits.
            state_d   = ARB_STALL;
        end
    end

    // State register; reset parks the pointer on RD so W0 goes first.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            rd_gnt_q  <= 1'b0;
            wr_data_q <= '0;
            occ_q     <= '0;
            last_q    <= REQ_RD;
            state_q   <= ARB_IDLE;
        end else begin
            wr_en_q   <= wr_en_d;
            rd_en_q   <= rd_en_d;
            gnt0_q    <= gnt0_d;
            gnt1_q    <= gnt1_d;
            rd_gnt_q  <= rd_gnt_d;
            wr_data_q <= wr_data_d;
            occ_q     <= occ_d;
            last_q    <= last_d;
            state_q   <= state_d;
        end
    end

    assign bus.wr_en   = wr_en_q;
    assign bus.rd_en   = rd_en_q;
    assign bus.gnt0    = gnt0_q;
    assign bus.gnt1    = gnt1_q;
    assign bus.rd_gnt  = rd_gnt_q;
    assign bus.wr_data = wr_data_q;
    assign bus.occ     = occ_q;
    assign bus.full    = full_w;
    assign bus.empty   = empty_w;
    assign bus.state   = state_q;

endmodule

// File: tb/tb_fifo_arbiter.sv
// Directed bench for fifo_arbiter with hand-computed expectations.
module tb_fifo_arbiter;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    fifo_arbiter_if #(.DATA_WIDTH(32), .CNT_W(4)) bus ();

    fifo_arbiter #(.DATA_WIDTH(32), .DEPTH(8), .CNT_W(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
        chk("excl", 32'(bus.wr_en && bus.rd_en), 32'd0);
    endtask

    initial begin
        bus.req0 = 0; bus.req1 = 0; bus.rd_req = 0;
        bus.din0 = 32'hA5; bus.din1 = 32'h5A;

        // Reset state
        #12;
        chk("rst_wr_en", 32'(bus.wr_en), 0);
        chk("rst_rd_en", 32'(bus.rd_en), 0);
        chk("rst_occ",   32'(bus.occ), 0);
        chk("rst_empty", 32'(bus.empty), 1);
        chk("rst_full",  32'(bus.full), 0);
        chk("rst_state", 32'(bus.state), 0);
        chk("rst_wdata", bus.wr_data, 0);

        // Single producer streams every other cycle until full
        reset_n = 1;
        bus.req0 = 1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("fill_wr_en", 32'(bus.wr_en), 1);
            chk("fill_gnt0",  32'(bus.gnt0), 1);
            chk("fill_wdata", bus.wr_data, 32'hA5);
            chk("fill_occ",   32'(bus.occ), 32'(i + 1));
            step();
            chk("fill_gap",   32'(bus.wr_en), 0);
            chk("fill_state", 32'(bus.state), (i == 7) ? 32'd3 : 32'd0);
        end
        chk("full_flag", 32'(bus.full), 1);
        step();
        chk("no_ninth",   32'(bus.wr_en), 0);
        chk("full_stall", 32'(bus.state), 3);
        chk("full_occ",   32'(bus.occ), 8);

        // Full: read is served first, writer on the following edge
        bus.rd_req = 1;
        step();
        chk("full_rd",     32'(bus.rd_gnt), 1);
        chk("full_rd_occ", 32'(bus.occ), 7);
        chk("full_rd_st",  32'(bus.state), 2);
        step();
        chk("full_w0",     32'(bus.gnt0), 1);
        chk("full_w0_occ", 32'(bus.occ), 8);
        bus.req0 = 0; bus.rd_req = 0;
        step();
        chk("quiet_state", 32'(bus.state), 0);

        // Reset mid-grant takes effect immediately
        reset_n = 0;
        #2;
        reset_n = 1;
        bus.req0 = 1;
        step();
        chk("pre_rst_wr_en", 32'(bus.wr_en), 1);
        bus.req0 = 0;
        #2 reset_n = 0;
        #1;
        chk("mid_rst_wr_en", 32'(bus.wr_en), 0);
        chk("mid_rst_gnt0",  32'(bus.gnt0), 0);
        chk("mid_rst_occ",   32'(bus.occ), 0);
        chk("mid_rst_empty", 32'(bus.empty), 1);
        chk("mid_rst_state", 32'(bus.state), 0);
        chk("mid_rst_wdata", bus.wr_data, 0);

        // Read at empty stalls; one write makes it eligible next edge
        @(negedge clk);
        reset_n = 1;
        bus.rd_req = 1;
        step();
        chk("empty_rd_en", 32'(bus.rd_en), 0);
        chk("empty_stall", 32'(bus.state), 3);
        chk("empty_flag",  32'(bus.empty), 1);
        bus.req1 = 1;
        step();
        chk("w1_gnt",   32'(bus.gnt1), 1);
        chk("w1_wdata", bus.wr_data, 32'h5A);
        chk("w1_occ",   32'(bus.occ), 1);
        bus.req1 = 0;
        step();
        chk("rd_after_w", 32'(bus.rd_gnt), 1);
        chk("rd_occ",     32'(bus.occ), 0);
        bus.rd_req = 0;
        step();
        chk("rd_done_st", 32'(bus.state), 0);

        // Reach occ=4 with last=RD, then all three requesters
        reset_n = 0;
        #2 reset_n = 1;
        bus.req0 = 1; bus.req1 = 1;
        for (int i = 0; i < 5; i++) step();
        chk("pre_occ5", 32'(bus.occ), 5);
        bus.req0 = 0; bus.req1 = 0; bus.rd_req = 1;
        step();
        chk("pre_rd",   32'(bus.rd_gnt), 1);
        chk("pre_occ4", 32'(bus.occ), 4);
        bus.req0 = 1; bus.req1 = 1;
        step();
        chk("rr_w0",   32'(bus.gnt0), 1);
        chk("rr_occ5", 32'(bus.occ), 5);
        step();
        chk("rr_w1",   32'(bus.gnt1), 1);
        chk("rr_occ6", 32'(bus.occ), 6);
        step();
        chk("rr_rd",    32'(bus.rd_gnt), 1);
        chk("rr_occ5b", 32'(bus.occ), 5);
        step();
        chk("rr_w0b",   32'(bus.gnt0), 1);
        chk("rr_occ6b", 32'(bus.occ), 6);

        // Withdraw req1 just before its turn: it is skipped
        bus.req1 = 0;
        step();
        chk("skip_gnt1", 32'(bus.gnt1), 0);
        chk("skip_rd",   32'(bus.rd_gnt), 1);
        chk("skip_occ",  32'(bus.occ), 5);
        step();
        chk("skip_w0",   32'(bus.gnt0), 1);
        chk("skip_occ2", 32'(bus.occ), 6);
        step();
        chk("skip_gnt1b", 32'(bus.gnt1), 0);
        chk("skip_rd2",   32'(bus.rd_gnt), 1);
        bus.req0 = 0; bus.rd_req = 0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_arbiter.md
# fifo_arbiter

Scheduler in front of the 8-entry FIFO. It shares the FIFO write port between two producers and the read port with one consumer. It issues at most one operation per cycle, and never asserts `wr_en` and `rd_en` together, which the FIFO would treat as NO_OP. It tracks occupancy itself, so the FIFO never receives a write when full or a read when empty; the FIFO never enters WR_ERROR or RD_ERROR.

## Interface
Parameters:
- `DATA_WIDTH`, 32, width of producer data and FIFO write data.
- `DEPTH`, 8, FIFO capacity; must match the FIFO instance.
- `CNT_W`, 4, width of occupancy; must hold 0..DEPTH.

Ports:
- `clk` in 1: the single clock; all state updates on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `req0`, `req1` in 1: producer write requests, held until granted.
- `din0`, `din1` in DATA_WIDTH: producer data, stable while the matching req is high.
- `rd_req` in 1: consumer read request, held until granted.
- `wr_en`, `rd_en` out 1: FIFO strobes, registered, mutually exclusive.
- `wr_data` out DATA_WIDTH: registered copy of the granted producer's din.
- `gnt0`, `gnt1`, `rd_gnt` out 1: one-cycle grant pulses, coincident with the strobe they cause.
- `occ` out CNT_W: shadow occupancy, including the operation currently on the strobes.
- `full`, `empty` out 1: decoded from occ (occ==DEPTH, occ==0).
- `state` out 2: IDLE=00, WRITE=01, READ=10, STALL=11.

## Operation
- Eligibility is evaluated each cycle from the current (registered) signals:
  - W0 when `req0 && occ<DEPTH && !gnt0`.
  - W1 when `req1 && occ<DEPTH && !gnt1`.
  - RD when `rd_req && occ>0 && !rd_gnt`.
- A requester granted this cycle is excluded at this edge. A continuously held req is therefore served at most every other cycle.
- Arbitration is round-robin over the ring W0→W1→RD→W0.
  - The search starts at the member after the last granted one (pointer `last`).
  - Exactly one eligible member is picked.
  - `last` updates only on a grant.
- At the edge the registered outputs load as follows:
  - Pick W0/W1: `wr_en`=1, the matching gnt=1, `wr_data`=din0/din1, `occ`+1.
  - Pick RD: `rd_en`=1, `rd_gnt`=1, `occ`−1.
  - No pick: all strobes and grants 0; `wr_data` holds its value.
- `state` next value:
  - WRITE or READ per the pick.
  - STALL if any req is high but nothing is eligible because of full/empty.
  - IDLE otherwise.
- Arithmetic: occ is unsigned, never exceeds DEPTH, never underflows; eligibility guarantees both, with no saturation logic.
- Requests are sampled only by the arbiter. Deasserting req before its grant withdraws the request silently.

## Timing
- Reset (asynchronous, `reset_n`=0), effective immediately, including mid-grant:
  - `wr_en`=`rd_en`=`gnt0`=`gnt1`=`rd_gnt`=0, `wr_data`=0, `occ`=0.
  - `full`=0, `empty`=1, `state`=IDLE.
  - `last`=RD, so W0 has first priority.
- Release is synchronous: arbitration starts on the first rising edge with `reset_n`=1.
- Latency: a request high at edge t produces strobe and grant during cycle t+1, if eligible and it wins.
- Full boundary: occ==DEPTH blocks both writers. A pending RD is still served, and writers become eligible from the next edge.
- Empty boundary: occ==0 blocks RD. A write issued at edge t makes RD eligible at edge t+1.
- Simultaneous requests are resolved by round-robin only; there is no fixed priority after reset.
- A single requester streams at one operation per two cycles. Two or more active requesters can fill every cycle.

## Structure
- Shared package `fifo_pkg`:
  - FIFO state encodings (INIT, WRITE, READ, WR_ERROR, RD_ERROR, NO_OP).
  - Arbiter state encodings (IDLE, WRITE, READ, STALL).
  - `DEPTH` and the requester index constants.
- Sub-module `rr_pick3`: combinational round-robin picker. Inputs are a 3-bit eligible vector and a 2-bit `last`; outputs are a one-hot pick and a valid flag.

## Test plan
- Reset mid-stream (`reset_n` low while `wr_en`=1) → all outputs drop in the same cycle; occ=0, empty=1, state=IDLE.
- Hold `req0` with din0=32'hA5 from occ=0 → wr_en/gnt0 pulse every other cycle, wr_data=32'hA5. After 8 grants occ=8, full=1, state=STALL, and no ninth wr_en.
- `rd_req` alone at occ=0 → no rd_en, state=STALL, empty=1. Then one `req1` grant → rd_gnt one cycle later, occ returns to 0.
- req0, req1 and rd_req all held from occ=4 after reset → grants in order W0, W1, RD, W0 on consecutive cycles. wr_en and rd_en are never high together, and occ follows 5, 6, 5, 6.
- occ=8 with req0 and rd_req held → RD granted first (occ=7), W0 on the next cycle (occ=8).
- req1 deasserted one cycle before its turn → it is skipped, and no gnt1 or wr_en is issued for it.
